fft_controller: RTL and testbench
=================================

Name: fft_controller

Overview:
- Top-level sequencer for the FFT memory/core pair.
- Counts input-pair writes from the IO side to detect a full frame, then drives the radix-2 DIT butterfly schedule (stage, butterfly index, operand/twiddle addresses) into the core.
- Inserts a pipeline drain between stages, then hands memory back to the IO side for readout.
- Generates the fft_busy and fft_valid signals consumed by the IO module.

Parameters:
- N, 32: FFT length; power of two, >= 4.
- address_width, $clog2(N): sample address width.
- stage_width, $clog2($clog2(N)): stage counter width; minimum 1.
- PIPE_LAT, 3: butterfly core write-back latency in cycles; >= 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; asserted when 0.
- en  in  1  clock enable; all state holds when 0.
- abort  in  1  synchronous frame abort; honoured only when en=1.
- in_wr_en  in  1  IO wrote one sample pair to memory this cycle.
- out_rd_en  in  1  IO read one sample pair from memory this cycle.
- bf_ready  in  1  core accepts the butterfly presented this cycle.
- bf_valid  out  1  butterfly request valid.
- bf_stage  out  stage_width  current stage, 0..log2(N)-1.
- bf_idx  out  address_width-1  butterfly index within the stage, 0..N/2-1.
- bf_addr_a  out  address_width  top operand address.
- bf_addr_b  out  address_width  bottom operand address.
- tw_addr  out  address_width-1  twiddle ROM index.
- fft_busy  out  1  core owns memory.
- fft_valid  out  1  results ready for readout.
- frame_done  out  1  one-cycle pulse when a frame is fully read out.
- state  out  2  debug: 0=LOAD, 1=COMPUTE, 2=DRAIN, 3=UNLOAD.

Behaviour:
- Let L = log2(N) and H = N/2.
- Reset (reset=0 at a clock edge):
  - state=LOAD; all counters 0.
  - bf_valid=0, fft_busy=0, fft_valid=0, frame_done=0.
  - Reset overrides en and abort.
- Abort (abort=1 and en=1): same effect as reset, except frame_done stays 0. Abort wins over any simultaneous strobe or handshake.
- en=0: no state, counter or output register changes. Combinational address outputs still reflect the held registers.
- LOAD:
  - Each in_wr_en increments load_cnt.
  - On the strobe that brings load_cnt to H: load_cnt:=0, stage:=0, idx:=0, next state COMPUTE.
  - out_rd_en is ignored.
- COMPUTE:
  - bf_valid=1, fft_busy=1.
  - Handshake = bf_valid & bf_ready.
  - On a handshake with idx<H-1: idx+1.
  - On a handshake with idx=H-1: idx:=0, drain_cnt:=PIPE_LAT-1, next state DRAIN.
  - Without bf_ready, all outputs hold stable.
  - in_wr_en and out_rd_en are ignored.
- DRAIN:
  - bf_valid=0, fft_busy=1.
  - drain_cnt decrements each enabled cycle.
  - At drain_cnt=0: if stage<L-1, stage+1 and go to COMPUTE; else go to UNLOAD.
  - The state therefore lasts exactly PIPE_LAT enabled cycles.
- UNLOAD:
  - fft_busy=0, fft_valid=1.
  - Each out_rd_en increments rd_cnt.
  - On the strobe that brings rd_cnt to H: rd_cnt:=0, frame_done=1 for the next cycle only, next state LOAD.
  - in_wr_en is ignored.
- Address generation: combinational from the registered stage s and idx i. With half = 1<<s:
  - pos = i & (half-1).
  - grp = i >> s.
  - bf_addr_a = (grp << (s+1)) | pos.
  - bf_addr_b = bf_addr_a + half.
  - tw_addr = pos << (L-1-s), truncated to address_width-1 bits.
  - All arithmetic is unsigned; no overflow is possible within range.
- Outputs are registered from state, except the address/twiddle terms.
- Back-to-back frames are allowed: LOAD is re-entered the cycle after the last out_rd_en, and in_wr_en is accepted from that cycle.

Test Plan:
- N=8, PIPE_LAT=2, reset low for 2 cycles -> state=0, all flags 0. Then 4 in_wr_en strobes -> state=1 and bf_valid=1 the cycle after the 4th strobe.
- N=8, bf_ready held 1 -> observe the following (a,b,tw) tuples:
  - stage0: (0,1,0), (2,3,0), (4,5,0), (6,7,0).
  - stage1: (0,2,0), (1,3,2), (4,6,0), (5,7,2).
  - stage2: (0,4,0), (1,5,1), (2,6,2), (3,7,3).
  - Exactly 2 DRAIN cycles follow each stage.
  - fft_busy is high for 12+6=18 cycles.
- bf_ready toggled 1,0,0,1 during stage 1 -> bf_idx and addresses hold during the stalls; no butterfly is skipped or duplicated.
- UNLOAD with 4 out_rd_en strobes and gaps of 3 cycles -> fft_valid stays high until the 4th strobe; frame_done pulses exactly 1 cycle; state returns to 0.
- abort asserted mid-stage-1 together with bf_ready -> next cycle state=0, bf_valid=0, fft_busy=0, frame_done=0. A fresh 4-strobe load then restarts at stage 0, idx 0.
- en=0 for 5 cycles during DRAIN and LOAD -> counters freeze; the drain length in enabled cycles is still 2; in_wr_en strobes while en=0 are not counted.

Source files
------------

// File: rtl/fft_controller.sv
// fft_controller: frame sequencer for the FFT memory/core pair.
// Loads a frame, walks the radix-2 DIT schedule, drains, then unloads.
module fft_controller #(
  parameter int N             = 32,
  parameter int PIPE_LAT      = 3,
  parameter int address_width = $clog2(N),
  parameter int stage_width   =
    ($clog2($clog2(N)) < 1) ? 1 : $clog2($clog2(N))
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     abort,
  input  logic                     in_wr_en,
  input  logic                     out_rd_en,
  input  logic                     bf_ready,
  output logic                     bf_valid,
  output logic [stage_width-1:0]   bf_stage,
  output logic [address_width-2:0] bf_idx,
  output logic [address_width-1:0] bf_addr_a,
  output logic [address_width-1:0] bf_addr_b,
  output logic [address_width-2:0] tw_addr,
  output logic                     fft_busy,
  output logic                     fft_valid,
  output logic                     frame_done,
  output logic [1:0]               state
);

  localparam int L  = $clog2(N);
  localparam int IW = address_width - 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [stage_width-1:0] LAST_STAGE =
    stage_width'(L - 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DRAIN   = 2'd2,
    S_UNLOAD  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    load_cnt_q, load_cnt_d;
  logic [IW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [stage_width-1:0] stage_q, stage_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic             bf_valid_q, bf_valid_d;
  logic             fft_busy_q, fft_busy_d;
  logic             fft_valid_q, fft_valid_d;
  logic             frame_done_q, frame_done_d;

  logic [IW-1:0]            pos;
  logic [IW-1:0]            grp;
  logic [address_width-1:0] half;
  logic [address_width-1:0] base;

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    idx_d        = idx_q;
    stage_d      = stage_q;
    drain_cnt_d  = drain_cnt_q;
    bf_valid_d   = bf_valid_q;
    fft_busy_d   = fft_busy_q;
    fft_valid_d  = fft_valid_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        if (in_wr_en) begin
          if (load_cnt_q == '1) begin
            load_cnt_d = '0;
            stage_d    = '0;
            idx_d      = '0;
            state_d    = S_COMPUTE;
            bf_valid_d = 1'b1;
            fft_busy_d = 1'b1;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        if (bf_valid_q && bf_ready) begin
          if (idx_q == '1) begin
            idx_d       = '0;
            drain_cnt_d = DRAIN_INIT;
            state_d     = S_DRAIN;
            bf_valid_d  = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == '0) begin
          if (stage_q != LAST_STAGE) begin
            stage_d    = stage_q + 1'b1;
            state_d    = S_COMPUTE;
            bf_valid_d = 1'b1;
          end else begin
            state_d     = S_UNLOAD;
            fft_busy_d  = 1'b0;
            fft_valid_d = 1'b1;
          end
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      S_UNLOAD: begin
        if (out_rd_en) begin
          if (rd_cnt_q == '1) begin
            rd_cnt_d     = '0;
            frame_done_d = 1'b1;
            fft_valid_d  = 1'b0;
            state_d      = S_LOAD;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
    // Abort discards the frame and beats any strobe or handshake.
    if (abort) begin
      state_d      = S_LOAD;
      load_cnt_d   = '0;
      rd_cnt_d     = '0;
      idx_d        = '0;
      stage_d      = '0;
      drain_cnt_d  = '0;
      bf_valid_d   = 1'b0;
      fft_busy_d   = 1'b0;
      fft_valid_d  = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  // State registers; everything holds while en is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_LOAD;
      load_cnt_q   <= '0;
      rd_cnt_q     <= '0;
      idx_q        <= '0;
      stage_q      <= '0;
      drain_cnt_q  <= '0;
      bf_valid_q   <= 1'b0;
      fft_busy_q   <= 1'b0;
      fft_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (en) begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      idx_q        <= idx_d;
      stage_q      <= stage_d;
      drain_cnt_q  <= drain_cnt_d;
      bf_valid_q   <= bf_valid_d;
      fft_busy_q   <= fft_busy_d;
      fft_valid_q  <= fft_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Operand and twiddle addresses from the registered stage/index.
  // The mask shift saturates to all-ones in the last stage.
  always_comb begin
    half = address_width'(1) << stage_q;
    pos  = idx_q & ~({IW{1'b1}} << stage_q);
    grp  = idx_q >> stage_q;
    base = (({1'b0, grp} << stage_q) << 1) | {1'b0, pos};
  end

  assign bf_addr_a  = base;
  assign bf_addr_b  = base + half;
  assign tw_addr    = pos << (LAST_STAGE - stage_q);
  assign bf_stage   = stage_q;
  assign bf_idx     = idx_q;
  assign bf_valid   = bf_valid_q;
  assign fft_busy   = fft_busy_q;
  assign fft_valid  = fft_valid_q;
  assign frame_done = frame_done_q;
  assign state      = state_q;

endmodule

// File: tb/tb_fft_controller.sv
// tb_fft_controller: directed bench for fft_controller, N=8.
// Expected butterflies come from a scoreboard queue.
`timescale 1ns/1ps
module tb_fft_controller;

  localparam int N  = 8;
  localparam int PL = 2;
  localparam int L  = 3;

  logic       clk = 1'b0;
  logic       reset, en, abort;
  logic       in_wr_en, out_rd_en, bf_ready;
  logic       bf_valid;
  logic [1:0] bf_stage;
  logic [1:0] bf_idx;
  logic [2:0] bf_addr_a, bf_addr_b;
  logic [1:0] tw_addr;
  logic       fft_busy, fft_valid, frame_done;
  logic [1:0] state;

  typedef struct {
    int a;
    int b;
    int tw;
    int st;
    int ix;
  } exp_t;

  exp_t q[$];
  int   n_err = 0;
  int   n_chk = 0;

  fft_controller #(.N(N), .PIPE_LAT(PL)) dut (
    .clk(clk), .reset(reset), .en(en), .abort(abort),
    .in_wr_en(in_wr_en), .out_rd_en(out_rd_en),
    .bf_ready(bf_ready), .bf_valid(bf_valid),
    .bf_stage(bf_stage), .bf_idx(bf_idx),
    .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b),
    .tw_addr(tw_addr), .fft_busy(fft_busy),
    .fft_valid(fft_valid), .frame_done(frame_done),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference DIT schedule: groups of 2*half, twiddle stride N/(2*half).
  task automatic push_frame();
    for (int s = 0; s < L; s++) begin
      int h;
      h = 1 << s;
      for (int g = 0; g < N / (2 * h); g++) begin
        for (int j = 0; j < h; j++) begin
          exp_t e;
          e.a  = g * 2 * h + j;
          e.b  = e.a + h;
          e.tw = j * (N / (2 * h));
          e.st = s;
          e.ix = g * h + j;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic bf_check();
    exp_t e;
    if (q.size() == 0) begin
      n_chk++;
      n_err++;
      $error("FAIL sb_underflow observed=%0d expected=none",
             bf_addr_a);
      return;
    end
    e = q[0];
    chk("bf_addr_a", 32'(bf_addr_a), e.a);
    chk("bf_addr_b", 32'(bf_addr_b), e.b);
    chk("tw_addr", 32'(tw_addr), e.tw);
    chk("bf_stage", 32'(bf_stage), e.st);
    chk("bf_idx", 32'(bf_idx), e.ix);
    if (bf_ready) void'(q.pop_front());
  endtask

  task automatic load_frame();
    for (int i = 0; i < 3; i++) begin
      in_wr_en = 1'b1;
      @(negedge clk);
      in_wr_en = 1'b0;
      @(negedge clk);
    end
    chk("load_partial", 32'(state), 0);
    in_wr_en = 1'b1;
    @(negedge clk);
    in_wr_en = 1'b0;
    chk("load_state", 32'(state), 1);
    chk("load_valid", 32'(bf_valid), 1);
    chk("load_busy", 32'(fft_busy), 1);
    chk("load_stage0", 32'(bf_stage), 0);
    chk("load_idx0", 32'(bf_idx), 0);
  endtask

  task automatic compute(input bit stall, input bit freeze);
    int cyc = 0, busy = 0, drun = 0, stalls = 0, k = 0;
    bit froze = 1'b0;
    logic [3:0] pat = 4'b1001;
    bf_ready = 1'b1;
    while (state !== 2'd3 && cyc < 300) begin
      if (freeze && !froze && state === 2'd2) begin
        froze = 1'b1;
        en = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("freeze_state", 32'(state), 2);
          chk("freeze_valid", 32'(bf_valid), 0);
        end
        en = 1'b1;
      end
      if (fft_busy === 1'b1) busy++;
      if (state === 2'd2) drun++;
      else if (drun != 0) begin
        chk("drain_len", drun, PL);
        drun = 0;
      end
      if (stall && bf_stage == 2'd1 && bf_valid) begin
        bf_ready = pat[k % 4];
        k++;
      end else begin
        bf_ready = 1'b1;
      end
      if (bf_valid === 1'b1) begin
        bf_check();
        if (!bf_ready) stalls++;
      end
      @(negedge clk);
      cyc++;
    end
    bf_ready = 1'b0;
    chk("compute_done", 32'(state), 3);
    if (drun != 0) chk("drain_len", drun, PL);
    chk("busy_cycles", busy, 12 + 3 * PL + stalls);
    chk("sb_empty", q.size(), 0);
    chk("unload_valid", 32'(fft_valid), 1);
  endtask

  task automatic unload();
    for (int k = 0; k < 4; k++) begin
      chk("unl_valid", 32'(fft_valid), 1);
      in_wr_en  = 1'b1;
      out_rd_en = 1'b1;
      @(negedge clk);
      in_wr_en  = 1'b0;
      out_rd_en = 1'b0;
      if (k < 3) begin
        repeat (3) @(negedge clk);
        chk("unl_state", 32'(state), 3);
        chk("unl_done0", 32'(frame_done), 0);
      end
    end
    chk("unl_back_load", 32'(state), 0);
    chk("unl_done_pulse", 32'(frame_done), 1);
    chk("unl_valid_off", 32'(fft_valid), 0);
    @(negedge clk);
    chk("unl_done_once", 32'(frame_done), 0);
  endtask

  initial begin
    int cyc;
    reset = 1'b0; en = 1'b1; abort = 1'b0;
    in_wr_en = 1'b0; out_rd_en = 1'b0; bf_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_valid", 32'(bf_valid), 0);
    chk("rst_busy", 32'(fft_busy), 0);
    chk("rst_fvalid", 32'(fft_valid), 0);
    chk("rst_done", 32'(frame_done), 0);
    reset = 1'b1;

    // Strobes while disabled must not count.
    en = 1'b0;
    in_wr_en = 1'b1;
    repeat (5) @(negedge clk);
    in_wr_en = 1'b0;
    en = 1'b1;
    chk("en0_load_state", 32'(state), 0);
    load_frame();
    push_frame();
    compute(1'b0, 1'b1);
    unload();

    // Back-to-back frame with stage-1 stalls.
    load_frame();
    push_frame();
    compute(1'b1, 1'b0);
    unload();

    // Abort in stage 1 alongside a handshake.
    load_frame();
    push_frame();
    bf_ready = 1'b1;
    cyc = 0;
    while (!(bf_stage == 2'd1 && bf_idx == 2'd1 && bf_valid)
           && cyc < 100) begin
      if (bf_valid === 1'b1) bf_check();
      @(negedge clk);
      cyc++;
    end
    chk("abort_reach", 32'(bf_stage), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    bf_ready = 1'b0;
    chk("abort_state", 32'(state), 0);
    chk("abort_valid", 32'(bf_valid), 0);
    chk("abort_busy", 32'(fft_busy), 0);
    chk("abort_done", 32'(frame_done), 0);
    chk("abort_stage", 32'(bf_stage), 0);
    q.delete();

    load_frame();
    push_frame();
    compute(1'b0, 1'b0);
    unload();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
